// File: rtl/mbus_tx_arbiter_ice.sv
// Two-requester arbiter (A = host, B = GOC) sharing one MBus layer TX interface; grant locked per message incl. response.
// Latency: TX_REQ follows the winner's REQ one cycle after it is sampled in IDLE; mux paths are combinational while BUSY.
// Backpressure: non-granted requester sees no ACK/SUCC/FAIL and simply holds REQ until the current message's RESP completes.
module mbus_tx_arbiter_ice #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLKIN,
    input  logic              RESETn,
    input  logic [ADDR_W-1:0] A_TX_ADDR,
    input  logic [DATA_W-1:0] A_TX_DATA,
    input  logic              A_TX_PEND,
    input  logic              A_TX_REQ,
    input  logic              A_TX_PRIORITY,
    output logic              A_TX_ACK,
    output logic              A_TX_SUCC,
    output logic              A_TX_FAIL,
    input  logic              A_TX_RESP_ACK,
    input  logic [ADDR_W-1:0] B_TX_ADDR,
    input  logic [DATA_W-1:0] B_TX_DATA,
    input  logic              B_TX_PEND,
    input  logic              B_TX_REQ,
    input  logic              B_TX_PRIORITY,
    output logic              B_TX_ACK,
    output logic              B_TX_SUCC,
    output logic              B_TX_FAIL,
    input  logic              B_TX_RESP_ACK,
    output logic [ADDR_W-1:0] TX_ADDR,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_PEND,
    output logic              TX_REQ,
    output logic              TX_PRIORITY,
    input  logic              TX_ACK,
    input  logic              TX_SUCC,
    input  logic              TX_FAIL,
    output logic              TX_RESP_ACK,
    output logic              BUSY,
    output logic              GRANT_B
);

    typedef enum logic [2:0] {
        IDLE,
        WORD,
        WAIT_ACKLO,
        INTERWORD,
        WAIT_RESULT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic   grant_b, grant_b_nxt;
    logic   rr_ptr, rr_ptr_nxt;     // 0 = A next in a tie, 1 = B
    logic   pend_q, pend_q_nxt;

    logic busy;
    logic g_req, g_pend, g_resp_ack;
    logic a_elig, b_elig, pick_b;
    logic result;

    assign busy       = (state != IDLE);
    assign g_req      = grant_b ? B_TX_REQ      : A_TX_REQ;
    assign g_pend     = grant_b ? B_TX_PEND     : A_TX_PEND;
    assign g_resp_ack = grant_b ? B_TX_RESP_ACK : A_TX_RESP_ACK;
    assign result     = TX_SUCC | TX_FAIL;

    // A requester still holding RESP_ACK from its last message is not eligible yet
    assign a_elig = A_TX_REQ & ~A_TX_RESP_ACK;
    assign b_elig = B_TX_REQ & ~B_TX_RESP_ACK;

    // Winner selection: lone requester, else priority, else round-robin pointer
    always_comb begin
        pick_b = b_elig;
        if (a_elig && b_elig) begin
            pick_b = (A_TX_PRIORITY != B_TX_PRIORITY) ? B_TX_PRIORITY : rr_ptr;
        end
    end

    // State, grant, round-robin pointer and pending-word flag registers
    always_ff @(posedge CLKIN or negedge RESETn) begin
        if (!RESETn) begin
            state   <= IDLE;
            grant_b <= 1'b0;
            rr_ptr  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_b <= grant_b_nxt;
            rr_ptr  <= rr_ptr_nxt;
            pend_q  <= pend_q_nxt;
        end
    end

    // Message sequencing; a SUCC/FAIL anywhere mid-message jumps straight to RESP
    always_comb begin
        state_nxt   = state;
        grant_b_nxt = grant_b;
        rr_ptr_nxt  = rr_ptr;
        pend_q_nxt  = pend_q;
        case (state)
            IDLE: begin
                if (a_elig || b_elig) begin
                    grant_b_nxt = pick_b;
                    state_nxt   = WORD;
                end
            end
            WORD: begin
                if (result) begin
                    state_nxt = RESP;
                end else if (TX_ACK) begin
                    pend_q_nxt = g_pend;
                    state_nxt  = WAIT_ACKLO;
                end
            end
            WAIT_ACKLO: begin
                if (result) begin
                    state_nxt = RESP;
                end else if (!g_req && !TX_ACK) begin
                    state_nxt = pend_q ? INTERWORD : WAIT_RESULT;
                end
            end
            INTERWORD: begin
                if (result) begin
                    state_nxt = RESP;
                end else if (g_req) begin
                    state_nxt = WORD;
                end
            end
            WAIT_RESULT: begin
                if (result) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (g_resp_ack && !result) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ~grant_b;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request mux toward the layer and response demux toward the granted requester
    always_comb begin
        TX_ADDR     = '0;
        TX_DATA     = '0;
        TX_PEND     = 1'b0;
        TX_REQ      = 1'b0;
        TX_PRIORITY = 1'b0;
        A_TX_ACK    = 1'b0;
        A_TX_SUCC   = 1'b0;
        A_TX_FAIL   = 1'b0;
        B_TX_ACK    = 1'b0;
        B_TX_SUCC   = 1'b0;
        B_TX_FAIL   = 1'b0;
        if (busy) begin
            if (grant_b) begin
                TX_ADDR     = B_TX_ADDR;
                TX_DATA     = B_TX_DATA;
                TX_PEND     = B_TX_PEND;
                TX_REQ      = B_TX_REQ;
                TX_PRIORITY = B_TX_PRIORITY;
                B_TX_ACK    = TX_ACK;
                B_TX_SUCC   = TX_SUCC;
                B_TX_FAIL   = TX_FAIL;
            end else begin
                TX_ADDR     = A_TX_ADDR;
                TX_DATA     = A_TX_DATA;
                TX_PEND     = A_TX_PEND;
                TX_REQ      = A_TX_REQ;
                TX_PRIORITY = A_TX_PRIORITY;
                A_TX_ACK    = TX_ACK;
                A_TX_SUCC   = TX_SUCC;
                A_TX_FAIL   = TX_FAIL;
            end
        end
    end

    assign TX_RESP_ACK = (state == RESP) & g_resp_ack;
    assign BUSY        = busy;
    assign GRANT_B     = grant_b;

endmodule
